// File: rtl/alu32_mul_seq.sv
// Sequential 32x32 unsigned shift-and-add multiplier that borrows an external
// alu32 adder, one partial-sum add per clock, producing a 64-bit product.
module alu32_mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_c
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] ALU_OP_ADD = 3'b110;

    state_t      state_q, state_d;
    logic [31:0] m_reg_q, m_reg_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] product_q, product_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [63:0] shifted_s;

    // Operand steering toward the shared ALU: add M only when the current multiplier bit is set
    always_comb begin
        alu_a  = acc_hi_q;
        alu_op = ALU_OP_ADD;
        if ((state_q == RUN) && acc_lo_q[0]) begin
            alu_b = m_reg_q;
        end else begin
            alu_b = 32'h0000_0000;
        end
    end

    // 65-bit partial sum {carry, sum, low half} shifted right by one
    assign shifted_s = {alu_c, alu_result, acc_lo_q[31:1]};

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        m_reg_d   = m_reg_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_reg_d  = multiplicand;
                    acc_hi_d = 32'h0000_0000;
                    acc_lo_d = multiplier;
                    cnt_d    = 5'd0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_hi_d = shifted_s[63:32];
                acc_lo_d = shifted_s[31:0];
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    product_d = shifted_s;
                    state_d   = DONE;
                end else begin
                    state_d   = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN) || (state_d == DONE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            m_reg_q   <= 32'h0000_0000;
            acc_hi_q  <= 32'h0000_0000;
            acc_lo_q  <= 32'h0000_0000;
            cnt_q     <= 5'd0;
            product_q <= 64'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_reg_q   <= m_reg_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_alu32_mul_seq.sv
// Randomized self-checking bench for alu32_mul_seq with a behavioural alu32 adder
// and a plain-arithmetic 64-bit reference product.
module tb_alu32_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_c;

    int checks;
    int failures;

    alu32_mul_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_c        (alu_c)
    );

    // Behavioural alu32: only the add operation matters here
    assign {alu_c, alu_result} = (alu_op == 3'b110) ? ({1'b0, alu_a} + {1'b0, alu_b}) : 33'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // The ALU opcode must be add in every cycle
    always @(negedge clk) begin
        check_eq("alu_op", {61'd0, alu_op}, 64'd6);
    end

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
        logic [63:0] wm;
        logic [63:0] wq;
        wm = {32'd0, m};
        wq = {32'd0, q};
        return wm * wq;
    endfunction

    // Caller is #1 after an edge with the DUT idle; returns #1 after the edge leaving DONE
    task automatic run_mul(input logic [31:0] m, input logic [31:0] q, input bit chk_zero);
        logic [63:0] prev;
        logic [63:0] exp;
        int lat;
        prev = product;
        exp  = ref_mul(m, q);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        check_eq("busy_rise", {63'd0, busy}, 64'd1);
        lat = 0;
        while (!done && lat < 40) begin
            if (chk_zero) check_eq("zero_alu_b", {32'd0, alu_b}, 64'd0);
            check_eq("product_hold", product, prev);
            @(posedge clk); #1;
            lat++;
        end
        check_eq("done_latency", 64'(lat), 64'd32);
        check_eq("product", product, exp);
        check_eq("busy_at_done", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        check_eq("done_pulse", {63'd0, done}, 64'd0);
        check_eq("busy_fall", {63'd0, busy}, 64'd0);
    endtask

    logic [31:0] ops_m [0:127];
    logic [31:0] ops_q [0:127];

    initial begin
        int ndone;
        int dones_seen;
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_product", product, 64'd0);
        check_eq("rst_alu_a", {32'd0, alu_a}, 64'd0);
        check_eq("rst_alu_b", {32'd0, alu_b}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_mul(32'd3, 32'd5, 1'b0);
        check_eq("3x5", product, 64'h0000_0000_0000_000F);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_eq("max_x_max", product, 64'hFFFF_FFFE_0000_0001);
        run_mul(32'h8000_0000, 32'd2, 1'b0);
        check_eq("msb_x_2", product, 64'h0000_0001_0000_0000);
        run_mul(32'd0, 32'hDEAD_BEEF, 1'b1);
        check_eq("zero_x", product, 64'h0);

        // start held high with operands changing every cycle
        start = 1'b1;
        dones_seen = 0;
        for (int n = 0; n < 110; n++) begin
            ops_m[n]     = $urandom;
            ops_q[n]     = $urandom;
            multiplicand = ops_m[n];
            multiplier   = ops_q[n];
            @(posedge clk); #1;
            if (done) begin
                dones_seen++;
                ndone = n - 32;
                check_eq("held_done_phase", 64'(ndone % 34), 64'd0);
                if (ndone >= 0) check_eq("held_product", product, ref_mul(ops_m[ndone], ops_q[ndone]));
            end
        end
        check_eq("held_done_count", 64'(dones_seen), 64'd3);
        start = 1'b0;
        // drain the multiply begun at edge 102
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
        end
        check_eq("held_idle", {63'd0, busy}, 64'd0);

        // reset ten cycles into 7 x 9
        multiplicand = 32'd7;
        multiplier   = 32'd9;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        check_eq("abort_product", product, 64'd0);
        check_eq("abort_done", {63'd0, done}, 64'd0);
        dones_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) dones_seen++;
        end
        check_eq("abort_no_done", 64'(dones_seen), 64'd0);
        run_mul(32'd7, 32'd9, 1'b0);
        check_eq("7x9_after_abort", product, 64'd63);

        for (int i = 0; i < 1000; i++) begin
            run_mul($urandom, $urandom, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
